cga_vram_arbiter: RTL and testbench

CGA_VRAM_ARBITER -- requirements
Module: cga_vram_arbiter

---
 rtl/cga_vram_arbiter.sv | 158 +++++++++++++++
 tb/tb_cga_vram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_vram_arbiter.sv
// CGA framebuffer arbiter: video fetch owns the RAM, the CPU gets one
// slot per 32-clock sequencer frame and is held off with ISA wait states.
module cga_vram_arbiter #(
  parameter logic [4:0] CPU_SLOT     = 5'd17,
  parameter bit         USE_BUS_WAIT = 1'b1
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic [4:0]  clk_seq,
  input  logic        video_req,
  input  logic [14:0] video_a,
  input  logic [14:0] bus_a,
  input  logic        bus_mem_cs,
  input  logic        bus_memr_l,
  input  logic        bus_memw_l,
  input  logic [7:0]  bus_d,
  output logic [7:0]  bus_out,
  output logic        bus_rdy,
  output logic [14:0] ram_a,
  output logic        ram_we_l,
  output logic [7:0]  ram_wd,
  input  logic [7:0]  ram_rd
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SLOT,
    ACCESS,
    CAPTURE,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic rd_m;
  logic rd_s;
  logic rd_p;
  logic wr_m;
  logic wr_s;
  logic wr_p;
  logic [1:0] fill;
  logic rd_arm;
  logic wr_arm;

  logic [14:0] a_q;
  logic [7:0]  d_q;
  logic        is_wr;
  logic        orphan;
  logic        rdy_q;

  logic rd_rise;
  logic wr_rise;
  logic trig_rd;
  logic trig_wr;
  logic slot_ok;
  logic strobe_on;
  logic access;
  logic wr_go;

  // A strobe only arms once it has been seen released after reset,
  // so a strobe still held from before reset never fires.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      rd_m   <= 1'b0;
      rd_s   <= 1'b0;
      rd_p   <= 1'b0;
      wr_m   <= 1'b0;
      wr_s   <= 1'b0;
      wr_p   <= 1'b0;
      fill   <= 2'b00;
      rd_arm <= 1'b0;
      wr_arm <= 1'b0;
    end else begin
      rd_m <= ~bus_memr_l;
      rd_s <= rd_m;
      rd_p <= rd_s;
      wr_m <= ~bus_memw_l;
      wr_s <= wr_m;
      wr_p <= wr_s;
      fill <= {fill[0], 1'b1};
      if (fill[1] && !rd_s) rd_arm <= 1'b1;
      if (fill[1] && !wr_s) wr_arm <= 1'b1;
    end
  end

  assign rd_rise   = rd_s & ~rd_p & rd_arm;
  assign wr_rise   = wr_s & ~wr_p & wr_arm;
  assign trig_rd   = rd_rise & ~wr_s;
  assign trig_wr   = wr_rise & ~rd_s;
  assign slot_ok   = (clk_seq == CPU_SLOT) & ~video_req;
  assign strobe_on = is_wr ? wr_s : rd_s;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus_mem_cs && (trig_rd || trig_wr))
          state_n = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (!is_wr && !rd_s)
          state_n = IDLE;
        else if (slot_ok)
          state_n = ACCESS;
      end
      ACCESS: begin
        state_n = is_wr ? DONE : CAPTURE;
      end
      CAPTURE: begin
        state_n = DONE;
      end
      DONE: begin
        if (orphan || !strobe_on)
          state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state   <= IDLE;
      rdy_q   <= 1'b1;
      bus_out <= 8'h00;
      a_q     <= '0;
      d_q     <= '0;
      is_wr   <= 1'b0;
      orphan  <= 1'b0;
    end else begin
      state <= state_n;
      rdy_q <= (state_n == IDLE) || (state_n == DONE);
      if (state == IDLE && state_n == WAIT_SLOT) begin
        a_q    <= bus_a;
        d_q    <= bus_d;
        is_wr  <= trig_wr;
        orphan <= 1'b0;
      end
      // A write whose strobe vanished still lands, but skips the DONE wait.
      if (state == WAIT_SLOT && is_wr && !wr_s)
        orphan <= 1'b1;
      if (state == CAPTURE)
        bus_out <= ram_rd;
      else if (state == DONE && state_n == IDLE)
        bus_out <= 8'h00;
    end
  end

  assign access   = (state == ACCESS);
  assign wr_go    = access & is_wr & ~video_req;
  assign ram_a    = access ? a_q : video_a;
  assign ram_we_l = ~wr_go;
  assign ram_wd   = wr_go ? d_q : 8'h00;
  assign bus_rdy  = USE_BUS_WAIT ? rdy_q : 1'b1;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Bench for cga_vram_arbiter: transaction-level timing model,
// per-cycle output compare and a small RAM model.
module tb_cga_vram_arbiter;

  logic        clk = 1'b0;
  logic        nRESET = 1'b0;
  logic [4:0]  clk_seq = 5'd0;
  logic        video_req = 1'b0;
  logic [14:0] video_a = 15'd0;
  logic [14:0] bus_a = 15'd0;
  logic        bus_mem_cs = 1'b0;
  logic        bus_memr_l = 1'b1;
  logic        bus_memw_l = 1'b1;
  logic [7:0]  bus_d = 8'd0;
  logic [7:0]  bus_out;
  logic        bus_rdy;
  logic [14:0] ram_a;
  logic        ram_we_l;
  logic [7:0]  ram_wd;
  logic [7:0]  ram_rd = 8'd0;

  cga_vram_arbiter dut (
    .clk        (clk),
    .nRESET     (nRESET),
    .clk_seq    (clk_seq),
    .video_req  (video_req),
    .video_a    (video_a),
    .bus_a      (bus_a),
    .bus_mem_cs (bus_mem_cs),
    .bus_memr_l (bus_memr_l),
    .bus_memw_l (bus_memw_l),
    .bus_d      (bus_d),
    .bus_out    (bus_out),
    .bus_rdy    (bus_rdy),
    .ram_a      (ram_a),
    .ram_we_l   (ram_we_l),
    .ram_wd     (ram_wd),
    .ram_rd     (ram_rd)
  );

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  // Expected-behaviour windows, in absolute cycle numbers.
  int acc_cyc = -1;
  int lo_s = -1;
  int lo_e = -2;
  int out_s = -1;
  int out_e = -2;
  int vid_blk = -1;
  bit          acc_wr = 1'b0;
  logic [14:0] acc_a = '0;
  logic [7:0]  acc_wd = '0;
  logic [7:0]  out_v = '0;

  logic [7:0]  mem [0:32767];
  logic [14:0] lat_a = '0;
  logic        lat_we = 1'b1;
  logic [7:0]  lat_wd = '0;
  logic [4:0]  prev_seq = '0;
  logic [4:0]  wr_seq = '0;

  function automatic bit vid(int k);
    return ((k % 32) < 4) || (k == vid_blk);
  endfunction

  function automatic int next_slot(int s);
    for (int k = s; k < s + 100; k++)
      if ((k % 32) == 17 && !vid(k)) return k;
    return -1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_to(int k);
    while (cyc < k) step();
  endtask

  task automatic align(int ph);
    while ((cyc % 32) != ph) step();
  endtask

  initial forever #5 clk = ~clk;

  // Stimulus timeline plus a RAM whose read data lags the address by one clk.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    clk_seq   = 5'(cyc % 32);
    video_req = vid(cyc);
    video_a   = 15'(cyc * 37 + 5);
    ram_rd    = mem[lat_a];
    if (!lat_we) mem[lat_a] = lat_wd;
  end

  initial forever begin
    @(negedge clk);
    begin
      int  k;
      bit  acc;
      k   = cyc;
      acc = (k == acc_cyc);
      check("ram_a", ram_a, acc ? acc_a : video_a);
      check("ram_we_l", ram_we_l, (acc && acc_wr) ? 1'b0 : 1'b1);
      check("ram_wd", ram_wd, (acc && acc_wr) ? acc_wd : 8'h00);
      check("bus_rdy", bus_rdy, (k >= lo_s && k <= lo_e) ? 1'b0 : 1'b1);
      check("bus_out", bus_out, (k >= out_s && k <= out_e) ? out_v : 8'h00);
      check("we_vs_video", {31'd0, (!ram_we_l && video_req)}, 32'd0);
      if (!ram_we_l) wr_seq = prev_seq;
      prev_seq = clk_seq;
      lat_a    = ram_a;
      lat_we   = ram_we_l;
      lat_wd   = ram_wd;
    end
  end

  task automatic txn(input bit wr, input logic [14:0] a,
                     input logic [7:0] dat, input int hold,
                     output int acc, output logic [7:0] got,
                     output logic [7:0] after);
    int p, c, d, r;
    p = cyc;
    bus_a = a;
    bus_d = dat;
    bus_mem_cs = 1'b1;
    if (wr) bus_memw_l = 1'b0;
    else    bus_memr_l = 1'b0;
    c = next_slot(p + 3);
    d = wr ? c + 2 : c + 3;
    r = d + hold;
    acc_cyc = c + 1;
    acc_wr  = wr;
    acc_a   = a;
    acc_wd  = dat;
    lo_s    = p + 3;
    lo_e    = wr ? c + 1 : c + 2;
    out_v   = wr ? 8'h00 : mem[a];
    out_s   = wr ? -1 : d;
    out_e   = wr ? -2 : r + 2;
    wait_to(p + 5);
    bus_a = ~a;
    bus_d = ~dat;
    wait_to(d);
    got = bus_out;
    wait_to(r);
    bus_memw_l = 1'b1;
    bus_memr_l = 1'b1;
    bus_mem_cs = 1'b0;
    wait_to(r + 3);
    after = bus_out;
    wait_to(r + 6);
    acc = c + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int acc, p, c, s0;
    logic [7:0] got, after;
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    mem[15'h7FFF] = 8'h5A;
    step(); step(); step();
    nRESET = 1'b1;
    step(); step();
    check("rst_rdy", bus_rdy, 1'b1);
    check("rst_out", bus_out, 8'h00);

    txn(1'b1, 15'h0123, 8'hA5, 2, acc, got, after);
    check("wr_slot", wr_seq, 5'd17);
    check("wr_mem", mem[15'h0123], 8'hA5);

    txn(1'b0, 15'h7FFF, 8'h00, 4, acc, got, after);
    check("rd_data", got, 8'h5A);
    check("rd_clear", after, 8'h00);

    s0 = next_slot(cyc + 3);
    vid_blk = s0;
    txn(1'b1, 15'h2222, 8'h3C, 1, acc, got, after);
    check("col_gap", acc - s0, 33);
    check("col_mem", mem[15'h2222], 8'h3C);

    // Read released while still waiting for the slot.
    align(20);
    p = cyc;
    bus_a = 15'h1111;
    bus_mem_cs = 1'b1;
    bus_memr_l = 1'b0;
    acc_cyc = -1;
    lo_s = p + 3;
    lo_e = p + 8;
    wait_to(p + 6);
    bus_memr_l = 1'b1;
    bus_mem_cs = 1'b0;
    wait_to(p + 40);
    check("abort_rdy", bus_rdy, 1'b1);

    // Write released while waiting still lands at the slot.
    align(20);
    p = cyc;
    bus_a = 15'h0555;
    bus_d = 8'h77;
    bus_mem_cs = 1'b1;
    bus_memw_l = 1'b0;
    c = next_slot(p + 3);
    acc_cyc = c + 1;
    acc_wr = 1'b1;
    acc_a = 15'h0555;
    acc_wd = 8'h77;
    lo_s = p + 3;
    lo_e = c + 1;
    wait_to(p + 6);
    bus_memw_l = 1'b1;
    bus_mem_cs = 1'b0;
    bus_a = 15'h7000;
    wait_to(c + 6);
    check("orphan_mem", mem[15'h0555], 8'h77);

    // Both strobes together are ignored.
    align(20);
    p = cyc;
    bus_a = 15'h0666;
    bus_d = 8'h99;
    bus_mem_cs = 1'b1;
    bus_memr_l = 1'b0;
    bus_memw_l = 1'b0;
    wait_to(p + 10);
    check("both_rdy", bus_rdy, 1'b1);
    wait_to(p + 40);
    bus_memr_l = 1'b1;
    bus_memw_l = 1'b1;
    bus_mem_cs = 1'b0;
    wait_to(p + 46);
    check("both_mem", mem[15'h0666], 8'h00);

    // Reset while a write waits; the held strobe must not retrigger.
    align(20);
    p = cyc;
    bus_a = 15'h0444;
    bus_d = 8'h3C;
    bus_mem_cs = 1'b1;
    bus_memw_l = 1'b0;
    acc_cyc = -1;
    lo_s = p + 3;
    lo_e = p + 5;
    wait_to(p + 6);
    nRESET = 1'b0;
    wait_to(p + 8);
    nRESET = 1'b1;
    wait_to(p + 51);
    bus_memw_l = 1'b1;
    bus_mem_cs = 1'b0;
    wait_to(p + 56);
    check("rst_mem", mem[15'h0444], 8'h00);

    txn(1'b0, 15'h0123, 8'h00, 2, acc, got, after);
    check("rd2_data", got, 8'hA5);
    check("rd2_clear", after, 8'h00);

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
